// File: rtl/button_conditioner_if.sv
// Bundle of per-channel button signals between the board pins and the game logic.
// The conditioner takes the slave side; whoever supplies raw presses takes the master side.
interface button_conditioner_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] press;
  logic [N_CH-1:0] pull;
  logic [N_CH-1:0] held;
  logic [N_CH-1:0] rel;

  modport master (output press, input pull, input held, input rel);
  modport slave  (input press, output pull, output held, output rel);
endinterface

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: synchroniser, debouncer, press/release strobes
// and an optional auto-repeat train while a button is held.
module button_conditioner #(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic reset,
  button_conditioner_if.slave btn
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  localparam logic [DW-1:0] DLAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RDLAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPLAST = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rptState_e;

  logic [N_CH-1:0] pullVec;
  logic [N_CH-1:0] heldVec;
  logic [N_CH-1:0] relVec;

  genvar ch;
  generate
    for (ch = 0; ch < N_CH; ch++) begin : gChan
      logic [SYNC_STAGES-1:0] syncQ, syncD;
      logic [DW-1:0]          dcntQ, dcntD;
      logic                   heldQ, heldD;
      logic                   pullQ, pullD;
      logic                   relQ, relD;
      rptState_e              stateQ, stateD;
      logic [RW-1:0]          rcntQ, rcntD;
      logic                   sOut;
      logic                   rise;
      logic                   fall;
      logic                   tick;

      assign sOut = syncQ[SYNC_STAGES-1];

      always_comb begin
        syncD[0] = btn.press[ch];
        for (int i = 1; i < SYNC_STAGES; i++) begin
          syncD[i] = syncQ[i-1];
        end
      end

      // held only moves after DEBOUNCE_CYCLES consecutive disagreeing samples
      always_comb begin
        dcntD = dcntQ;
        heldD = heldQ;
        rise  = 1'b0;
        fall  = 1'b0;
        if (sOut == heldQ) begin
          dcntD = '0;
        end else if (dcntQ == DLAST) begin
          heldD = sOut;
          dcntD = '0;
          rise  = sOut;
          fall  = ~sOut;
        end else begin
          dcntD = dcntQ + DW'(1);
        end
      end

      // A release always wins over a coinciding repeat terminal count
      always_comb begin
        stateD = stateQ;
        rcntD  = rcntQ;
        tick   = 1'b0;
        if (fall) begin
          stateD = IDLE;
          rcntD  = '0;
        end else begin
          case (stateQ)
            IDLE: begin
              if (rise && (REPEAT_EN != 0)) begin
                stateD = DELAY;
                rcntD  = '0;
              end
            end
            DELAY: begin
              if (rcntQ == RDLAST) begin
                tick   = 1'b1;
                rcntD  = '0;
                stateD = REPEAT;
              end else begin
                rcntD = rcntQ + RW'(1);
              end
            end
            REPEAT: begin
              if (rcntQ == RPLAST) begin
                tick  = 1'b1;
                rcntD = '0;
              end else begin
                rcntD = rcntQ + RW'(1);
              end
            end
            default: begin
              stateD = IDLE;
              rcntD  = '0;
            end
          endcase
        end
      end

      assign pullD = rise | tick;
      assign relD  = fall;

      always_ff @(posedge clk) begin
        if (reset) begin
          syncQ  <= '0;
          dcntQ  <= '0;
          heldQ  <= 1'b0;
          pullQ  <= 1'b0;
          relQ   <= 1'b0;
          stateQ <= IDLE;
          rcntQ  <= '0;
        end else begin
          syncQ  <= syncD;
          dcntQ  <= dcntD;
          heldQ  <= heldD;
          pullQ  <= pullD;
          relQ   <= relD;
          stateQ <= stateD;
          rcntQ  <= rcntD;
        end
      end

      assign pullVec[ch] = pullQ;
      assign heldVec[ch] = heldQ;
      assign relVec[ch]  = relQ;
    end
  endgenerate

  assign btn.pull = pullVec;
  assign btn.held = heldVec;
  assign btn.rel  = relVec;

endmodule
